// File: rtl/f_mem_responder.sv
// Word-organised memory responder for the CPU load/store path: valid/ready
// request side, configurable wait states, read-modify-write sub-word stores.
module f_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_MERGE,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_write;
    logic [1:0]         r_size;
    logic [IDX_W-1:0]   r_idx;
    logic [1:0]         r_lane;
    logic [31:0]        r_wdata;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    logic [31:0]        r_word;
    logic [31:0]        r_rdata;
    logic [31:0]        r_mem [DEPTH_WORDS];
    logic               w_req_err;
    logic               w_sub_store;
    logic [31:0]        w_merged;

    // Error check is made on the values being latched at the accept edge.
    assign w_req_err = (req_size == 2'b11)
                    || ((req_size == 2'b00) && (req_addr[1:0] != 2'b00))
                    || ((req_size == 2'b01) && req_addr[0])
                    || ({2'b00, req_addr[31:2]} >= DEPTH_L);

    assign w_sub_store = r_write && (r_size != 2'b00);

    always_comb begin
        w_merged = r_word;
        if (r_size == 2'b01) begin
            if (r_lane[1]) w_merged[31:16] = r_wdata[15:0];
            else           w_merged[15:0]  = r_wdata[15:0];
        end else begin
            case (r_lane)
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_req_err)             w_next = S_RESP;
                    else if (WAIT_CYCLES == 0) w_next = S_ACCESS;
                    else                       w_next = S_WAIT;
                end
            end
            S_WAIT:   if (r_cnt == '0) w_next = S_ACCESS;
            S_ACCESS: w_next = w_sub_store ? S_MERGE : S_RESP;
            S_MERGE:  w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write <= 1'b0;
            r_size  <= '0;
            r_idx   <= '0;
            r_lane  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_word  <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_size  <= req_size;
                        r_idx   <= req_addr[IDX_W+1:2];
                        r_lane  <= req_addr[1:0];
                        r_wdata <= req_wdata;
                        r_err   <= w_req_err;
                        r_cnt   <= CNT_LOAD;
                        r_rdata <= '0;
                    end
                end
                S_WAIT: if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                S_ACCESS: begin
                    r_word <= r_mem[r_idx];
                    if (!r_write) r_rdata <= r_mem[r_idx];
                end
                default: ;
            endcase
        end
    end

    // Array has no reset; commits happen only on the ACCESS/MERGE edges.
    always_ff @(posedge clk) begin
        if ((r_state == S_ACCESS) && r_write && (r_size == 2'b00))
            r_mem[r_idx] <= r_wdata;
        else if (r_state == S_MERGE)
            r_mem[r_idx] <= w_merged;
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_err   = (r_state == S_RESP) && r_err;
    assign resp_rdata = r_rdata;

endmodule

// File: tb/tb_f_mem_responder.sv
// Directed bench for f_mem_responder: one instance with one wait state
// (index 0) and one with none (index 1), sharing clock and reset.
module tb_f_mem_responder;

    logic             clk;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_write;
    logic [1:0][1:0]  req_size;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       req_ready;
    logic [1:0]       resp_valid;
    logic [1:0][31:0] resp_rdata;
    logic [1:0]       resp_err;

    int n_total;
    int n_bad;

    f_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid[0]),
        .req_write  (req_write[0]),
        .req_size   (req_size[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .req_ready  (req_ready[0]),
        .resp_valid (resp_valid[0]),
        .resp_rdata (resp_rdata[0]),
        .resp_err   (resp_err[0])
    );

    f_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid[1]),
        .req_write  (req_write[1]),
        .req_size   (req_size[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .req_ready  (req_ready[1]),
        .resp_valid (resp_valid[1]),
        .resp_rdata (resp_rdata[1]),
        .resp_err   (resp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Latency counts the accept edge as edge 1; -1 means no response seen.
    task automatic do_req(input int d, input logic wr, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_size[d]  = sz;
        req_addr[d]  = addr;
        req_wdata[d] = wd;
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat = 1;
        while (!resp_valid[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid[d]) lat = -1;
        rd = resp_rdata[d];
        er = resp_err[d];
    endtask

    task automatic req_chk(input string tag, input int d, input logic wr, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(d, wr, sz, addr, wd, rd, er, lat);
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
        check_val({tag, "_rdata"}, rd, exp_rd);
    endtask

    // Holds req_valid high with a load until two accepts, recording req_ready
    // and resp_valid at each of 12 falling edges.
    task automatic queued(input string tag, input int d, input logic [31:0] addr,
                          input logic [11:0] exp_rdy, input logic [11:0] exp_rv,
                          input logic [31:0] exp_rd);
        logic [11:0] rdy;
        logic [11:0] rv;
        int          acc;
        bit          drop;
        acc  = 0;
        drop = 1'b0;
        rdy  = '0;
        rv   = '0;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_write[d] = 1'b0;
        req_size[d]  = 2'b00;
        req_addr[d]  = addr;
        req_wdata[d] = '0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (drop) req_valid[d] = 1'b0;
            rdy[i] = req_ready[d];
            rv[i]  = resp_valid[d];
            if (resp_valid[d]) check_val({tag, "_rdata"}, resp_rdata[d], exp_rd);
            if (req_valid[d] && req_ready[d]) begin
                acc++;
                if (acc == 2) drop = 1'b1;
            end
        end
        req_valid[d] = 1'b0;
        check_val({tag, "_ready"}, {20'd0, rdy}, {20'd0, exp_rdy});
        check_val({tag, "_respv"}, {20'd0, rv}, {20'd0, exp_rv});
        check_val({tag, "_accepts"}, 32'(acc), 32'd2);
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_size  = '0;
        req_addr  = '0;
        req_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_ready", {31'd0, req_ready[0]}, 32'd1);
        check_val("rst_respv", {31'd0, resp_valid[0]}, 32'd0);
        check_val("rst_rdata", resp_rdata[0], 32'd0);
        reset = 1'b0;

        req_chk("st_word", 0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 3, 1'b0, 32'h0);
        req_chk("ld_word", 0, 1'b0, 2'b00, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF);
        req_chk("st_byte", 0, 1'b1, 2'b10, 32'h11, 32'h000000AA, 4, 1'b0, 32'h0);
        req_chk("ld_byte", 0, 1'b0, 2'b00, 32'h10, 32'h0, 3, 1'b0, 32'hDEADAAEF);
        req_chk("st_half", 0, 1'b1, 2'b01, 32'h12, 32'h00001234, 4, 1'b0, 32'h0);
        req_chk("ld_half", 0, 1'b0, 2'b00, 32'h10, 32'h0, 3, 1'b0, 32'h1234AAEF);

        req_chk("err_ldmis", 0, 1'b0, 2'b00, 32'h13, 32'h0, 1, 1'b1, 32'h0);
        req_chk("err_sthmis", 0, 1'b1, 2'b01, 32'h11, 32'h0000FFFF, 1, 1'b1, 32'h0);
        req_chk("err_size", 0, 1'b1, 2'b11, 32'h0, 32'hFFFFFFFF, 1, 1'b1, 32'h0);
        req_chk("ld_after_err", 0, 1'b0, 2'b00, 32'h10, 32'h0, 3, 1'b0, 32'h1234AAEF);

        req_chk("err_range", 0, 1'b0, 2'b00, 32'h400, 32'h0, 1, 1'b1, 32'h0);
        req_chk("st_top", 0, 1'b1, 2'b00, 32'h3FC, 32'hCAFEF00D, 3, 1'b0, 32'h0);
        req_chk("ld_top", 0, 1'b0, 2'b00, 32'h3FC, 32'h0, 3, 1'b0, 32'hCAFEF00D);

        req_chk("st_pre", 0, 1'b1, 2'b00, 32'h20, 32'h11111111, 3, 1'b0, 32'h0);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_size[0]  = 2'b00;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'h22222222;
        @(negedge clk);
        req_valid[0] = 1'b0;
        check_val("abort_inwait", {31'd0, req_ready[0]}, 32'd0);
        reset = 1'b1;
        #1;
        check_val("abort_ready", {31'd0, req_ready[0]}, 32'd1);
        check_val("abort_respv", {31'd0, resp_valid[0]}, 32'd0);
        check_val("abort_rdata", resp_rdata[0], 32'd0);
        @(negedge clk);
        reset = 1'b0;
        req_chk("ld_abort", 0, 1'b0, 2'b00, 32'h20, 32'h0, 3, 1'b0, 32'h11111111);

        queued("q_w1", 0, 32'h10, 12'hF11, 12'h088, 32'h1234AAEF);

        req_chk("w0_st", 1, 1'b1, 2'b00, 32'h40, 32'hA5A5A5A5, 2, 1'b0, 32'h0);
        req_chk("w0_ld", 1, 1'b0, 2'b00, 32'h40, 32'h0, 2, 1'b0, 32'hA5A5A5A5);
        req_chk("w0_stb", 1, 1'b1, 2'b10, 32'h43, 32'h0000003C, 3, 1'b0, 32'h0);
        req_chk("w0_err", 1, 1'b0, 2'b01, 32'h41, 32'h0, 1, 1'b1, 32'h0);
        queued("q_w0", 1, 32'h40, 12'hFC9, 12'h024, 32'h3CA5A5A5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/f_mem_responder.md
Name: f_mem_responder

Overview:
- Memory-side responder for the multicycle CPU's load/store path; serves the requester end of a valid/ready memory request interface.
- Holds DEPTH_WORDS 32-bit words.
- Inserts WAIT_CYCLES wait states per access.
- Performs read-modify-write for byte/halfword stores.
- Flags misaligned, out-of-range and reserved-size requests so the control unit can raise an exception.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words stored (word index = req_addr[31:2])
WAIT_CYCLES, 1, wait-state cycles inserted before each array access (0 allowed)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
req_valid  in  1  request present; requester holds all req_* stable until accepted
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 word, 01 halfword, 10 byte, 11 reserved
req_addr  in  32  byte address
req_wdata  in  32  store data; halfword in [15:0], byte in [7:0]
req_ready  out  1  high only in IDLE; request accepted on edge where req_valid && req_ready
resp_valid  out  1  one-cycle pulse: request complete
resp_rdata  out  32  full aligned word read (loads), 0 for stores and errors; valid only with resp_valid
resp_err  out  1  error qualifier, valid only with resp_valid

Behaviour:
- Reset values (asynchronous): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter 0. Array contents are not reset.
- States: IDLE, WAIT, ACCESS, MERGE, RESP.
- IDLE:
  - On acceptance, latch write, size, addr and wdata.
  - Error check on the latched request: size==11, OR size==00 && addr[1:0]!=0, OR size==01 && addr[0]!=0, OR addr[31:2] >= DEPTH_WORDS.
  - Error -> RESP with resp_err=1, rdata=0. No wait states, array untouched.
  - Otherwise -> WAIT (counter loaded WAIT_CYCLES-1), or directly to ACCESS if WAIT_CYCLES==0.
- WAIT: decrement counter; -> ACCESS when counter==0.
- ACCESS: read array[addr[31:2]] into an internal word buffer.
  - Load: rdata <= word, -> RESP.
  - Word store: write wdata to the array on this edge, -> RESP.
  - Sub-word store: -> MERGE.
- MERGE: write the merged word, -> RESP.
  - Little-endian lanes: byte lane = addr[1:0] (lane 0 = bits 7:0); halfword lane = addr[1] (0 = bits 15:0).
  - Untouched lanes keep their old value.
- RESP: resp_valid=1 for exactly one cycle, resp_err as latched; -> IDLE. req_ready returns high in the following cycle.
- Latency, counted as edges after the accept edge until the edge that raises resp_valid:
  - Loads and word stores: WAIT_CYCLES+2.
  - Sub-word stores: WAIT_CYCLES+3.
  - Errors: 1.
- Requests while busy: req_ready=0; requests are not queued and are ignored until IDLE.
- Back-to-back: a request held high across RESP is accepted on the first IDLE cycle. Minimum spacing between accepts is latency+1 edges.
- Reset mid-operation: returns to IDLE immediately and drops the response.
  - A store aborted before its ACCESS (word) or MERGE (sub-word) commit edge leaves the array unchanged.
  - A commit edge is never partially applied.
- A load following a store to the same word returns the stored data.
- Sub-word loads return the whole aligned word; lane selection and extension belong to the CPU's load-size logic.

Test Plan:
- WAIT_CYCLES=1. Store word 0xDEADBEEF @0x10, then load @0x10 -> store resp_valid 3 edges after accept; load resp_rdata=0xDEADBEEF at 3 edges; resp_err=0.
- Byte store 0xAA @0x11, then halfword store 0x1234 @0x12, then load @0x10 -> 0xDEADAAEF after the byte store, 0x1234AAEF after the halfword store; each sub-word store responds in 4 edges.
- Word load @0x13, halfword store @0x11, req_size=11 @0x0 -> each gives resp_err=1, rdata=0, resp_valid 1 edge after accept; array word @0x10 unchanged.
- Load @ DEPTH_WORDS*4 (0x400) -> resp_err=1; load @0x3FC -> resp_err=0.
- Store word 0x11111111 @0x20, then store 0x22222222 @0x20 with reset pulsed during WAIT; reload -> 0x11111111. After reset: req_ready=1, resp_valid=0, resp_rdata=0.
- req_valid held high for two queued loads -> req_ready low from accept until the cycle after RESP; exactly two resp_valid pulses, no duplicate accept. Repeat with WAIT_CYCLES=0 -> load latency 2.
